// File: rtl/drbg_pkg.sv
// Shared constants, state typedefs and the update FSM encoding for the CTR_DRBG datapath.
package drbg_pkg;
  localparam int KEYLEN   = 256;
  localparam int BLOCKLEN = 128;
  localparam int SEEDLEN  = KEYLEN + BLOCKLEN;
  localparam int NBLK     = SEEDLEN / BLOCKLEN;

  typedef logic [KEYLEN-1:0]   key_t;
  typedef logic [BLOCKLEN-1:0] block_t;
  typedef logic [SEEDLEN-1:0]  seed_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INC,
    ST_ENC,
    ST_WAIT,
    ST_MIX,
    ST_DONE
  } upd_state_e;
endpackage

// File: rtl/aes256_enc.sv
// Iterative AES-256 encryptor: one round per clock, round keys expanded on the fly
// in a sliding two-round-key window. done pulses 14 cycles after start is sampled.
module aes256_enc
  import drbg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEYLEN-1:0]   key,
  input  logic [BLOCKLEN-1:0] pt,
  output logic [BLOCKLEN-1:0] ct,
  output logic                done
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Byte i of the block is row i%4, column i/4; row r rotates left by r columns.
  function automatic block_t sub_shift(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic block_t mix_cols(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic block_t key_chain(input block_t a, input logic [31:0] t);
    logic [31:0] w0, w1, w2, w3;
    w0 = a[127:96] ^ t;
    w1 = a[95:64]  ^ w0;
    w2 = a[63:32]  ^ w1;
    w3 = a[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  block_t      state_q;
  key_t        rk_q;
  logic [7:0]  rcon_q;
  logic [3:0]  rnd_q;
  logic        busy_q;
  logic        done_q;
  block_t      round_out;
  block_t      next_rk;
  logic [31:0] last_w;

  // rk_q holds {previous, current} round key; odd rounds produce an even-index key.
  always_comb begin
    last_w    = rk_q[31:0];
    round_out = sub_shift(state_q);
    if (rnd_q != 4'd14) round_out = mix_cols(round_out);
    round_out = round_out ^ rk_q[127:0];
    if (rnd_q[0])
      next_rk = key_chain(rk_q[255:128],
                          sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon_q, 24'h0});
    else
      next_rk = key_chain(rk_q[255:128], sub_word(last_w));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rnd_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      if (start && !busy_q) begin
        busy_q <= 1'b1;
        rnd_q  <= 4'd1;
      end else if (busy_q) begin
        if (rnd_q == 4'd14) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          rnd_q <= rnd_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start && !busy_q) begin
      state_q <= pt ^ key[255:128];
      rk_q    <= key;
      rcon_q  <= 8'h01;
    end else if (busy_q) begin
      state_q <= round_out;
      rk_q    <= {rk_q[127:0], next_rk};
      if (rnd_q[0]) rcon_q <= xt(rcon_q);
    end
  end

  assign ct   = state_q;
  assign done = done_q;
endmodule

// File: rtl/ctr_drbg_update.sv
// CTR_DRBG_Update for AES-256 without derivation function: three keystream blocks
// from V+1..V+3 under Key, XORed with provided_data, become the new Key/V.
module ctr_drbg_update
  import drbg_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SEEDLEN-1:0]  provided_data,
  output logic [KEYLEN-1:0]   key,
  output logic [BLOCKLEN-1:0] v,
  output logic                done
);
  upd_state_e state_q;
  logic       start_q;
  logic       aes_start_q;
  logic       done_q;
  logic [1:0] blk_q;
  key_t       key_q;
  block_t     v_q;
  key_t       kw_q;
  block_t     vw_q;
  seed_t      pd_q;
  seed_t      temp_q;
  block_t     aes_ct;
  logic       aes_done;
  logic       accept;

  assign accept = (state_q == ST_IDLE) && start && !start_q;

  // start_q keeps sampling through reset, so a start held across reset is not a new request.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (rst) begin
      state_q     <= ST_IDLE;
      aes_start_q <= 1'b0;
      done_q      <= 1'b0;
      blk_q       <= 2'd0;
      key_q       <= '0;
      v_q         <= '0;
    end else begin
      done_q      <= 1'b0;
      aes_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            blk_q   <= 2'd0;
            state_q <= ST_INC;
          end
        end
        ST_INC: begin
          aes_start_q <= 1'b1;
          state_q     <= ST_ENC;
        end
        ST_ENC:  state_q <= ST_WAIT;
        ST_WAIT: begin
          if (aes_done) begin
            blk_q   <= blk_q + 2'd1;
            state_q <= (blk_q == 2'(NBLK-1)) ? ST_MIX : ST_INC;
          end
        end
        ST_MIX:  state_q <= ST_DONE;
        ST_DONE: begin
          key_q   <= temp_q[SEEDLEN-1:BLOCKLEN];
          v_q     <= temp_q[BLOCKLEN-1:0];
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pd_q <= provided_data;
      kw_q <= key_q;
      vw_q <= v_q;
    end
    if (state_q == ST_INC) vw_q <= vw_q + 128'd1;
    if (state_q == ST_WAIT && aes_done) begin
      case (blk_q)
        2'd0:    temp_q[383:256] <= aes_ct;
        2'd1:    temp_q[255:128] <= aes_ct;
        2'd2:    temp_q[127:0]   <= aes_ct;
        default: ;
      endcase
    end
    if (state_q == ST_MIX) temp_q <= temp_q ^ pd_q;
  end

  aes256_enc u_aes (
    .clk   (clk),
    .rst   (rst),
    .start (aes_start_q),
    .key   (kw_q),
    .pt    (vw_q),
    .ct    (aes_ct),
    .done  (aes_done)
  );

  assign key  = key_q;
  assign v    = v_q;
  assign done = done_q;
endmodule

// File: tb/tb_ctr_drbg_update.sv
// Randomized bench for ctr_drbg_update against a textbook AES-256 / CTR_DRBG_Update model.
module tb_ctr_drbg_update;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [383:0] provided_data;
  logic [255:0] key;
  logic [127:0] v;
  logic         done;

  always #5 clk = ~clk;

  ctr_drbg_update dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .provided_data (provided_data),
    .key           (key),
    .v             (v),
    .done          (done)
  );

  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb [256];
  logic [255:0] mk;
  logic [127:0] mv;
  int           lat_meas;
  int           lat_tmp;
  int           dones;
  int           lat_blk;
  int           off;
  logic [255:0] k0;
  logic [127:0] v0;
  logic [383:0] d;
  logic [383:0] ks;

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_x2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = gf_x2(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic [127:0] pt);
    logic [31:0]  w [60];
    logic [7:0]   st [4][4];
    logic [7:0]   cp [4][4];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] o;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gf_x2(rc);
      end else if (i % 8 == 4) begin
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) cp[r][c] = sb[st[r][c]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) st[r][c] = cp[r][(c+r)%4];
      if (rnd < 14) begin
        cp = st;
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            st[r][c] = gf_mul(8'h02, cp[r][c]) ^ gf_mul(8'h03, cp[(r+1)%4][c])
                     ^ cp[(r+2)%4][c] ^ cp[(r+3)%4][c];
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = st[r][c];
    return o;
  endfunction

  function automatic logic [383:0] drbg_ks(input logic [255:0] k, input logic [127:0] vv);
    logic [383:0] o;
    for (int i = 0; i < 3; i++) begin
      vv = vv + 128'd1;
      o[383-128*i -: 128] = aes_ref(k, vv);
    end
    return o;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One update: raise start for 'hold' cycles, watch done, compare with the model.
  task automatic run_update(input string tag, input logic [383:0] din, input int hold,
                            output int lat);
    logic [383:0] exp;
    logic [255:0] got_k;
    logic [127:0] got_v;
    int cyc, nd, unstable;
    exp = drbg_ks(mk, mv) ^ din;
    provided_data = din;
    start = 1'b1;
    cyc = 0; nd = 0; unstable = 0; lat = -1;
    got_k = '0; got_v = '0;
    while (1) begin
      @(posedge clk);
      #1 cyc++;
      if (cyc == hold) start = 1'b0;
      if (hold == 1 && cyc == 6) start = 1'b1;
      if (hold == 1 && cyc == 7) start = 1'b0;
      if (cyc == 2) provided_data = rand384();
      if (done) begin
        nd++;
        if (lat < 0) begin
          lat = cyc - 1;
          got_k = key;
          got_v = v;
        end
      end else if (lat < 0 && (key !== mk || v !== mv)) begin
        unstable++;
      end
      if (lat >= 0 && cyc >= lat + 9 && cyc >= hold) break;
      if (cyc >= 400) break;
    end
    start = 1'b0;
    check({tag, "_dones"}, 384'(nd), 384'(1));
    check({tag, "_key"}, 384'(got_k), 384'(exp[383:128]));
    check({tag, "_v"}, 384'(got_v), 384'(exp[127:0]));
    check({tag, "_stable"}, 384'(unstable), 384'(0));
    mk = exp[383:128];
    mv = exp[127:0];
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    provided_data = '0;
    build_sbox();
    check("aes_kat",
          384'(aes_ref(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                       128'h00112233445566778899aabbccddeeff)),
          384'(128'h8ea2b7ca516745bfeafc49904b496089));

    // Reset with start held high across release
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_key", 384'(key), 384'(0));
    check("rst_v", 384'(v), 384'(0));
    check("rst_done", 384'(done), 384'(0));
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 5) start = 1'b0;
      if (done) dones++;
    end
    check("rst_start_no_op", 384'(dones), 384'(0));
    check("rst_start_key", 384'({key, v}), 384'(0));
    mk = '0;
    mv = '0;

    // Instantiate-style update, start held well past done
    run_update("inst", {64'h0, {5{64'h0123456789abcdef}}}, 100, lat_meas);
    check("lat_form", 384'((lat_meas - 2) % 3), 384'(0));

    // XOR linearity from the zero state
    do_reset();
    mk = '0; mv = '0;
    run_update("lin0", '0, 1, lat_tmp);
    k0 = key; v0 = v;
    do_reset();
    mk = '0; mv = '0;
    d = rand384();
    run_update("lin1", d, 1, lat_tmp);
    check("linearity", {key, v}, {k0, v0} ^ d);

    // Force V to all ones, then the next update counts 0,1,2
    ks = drbg_ks(mk, mv);
    d = {rand384() >> 128, ks[127:0] ^ {128{1'b1}}};
    run_update("wrap_pre", d, 1, lat_tmp);
    check("wrap_v_ones", 384'(v), 384'({128{1'b1}}));
    run_update("wrap", rand384(), 1, lat_tmp);

    // Back-to-back chain
    for (int i = 0; i < 3; i++) run_update($sformatf("b2b%0d", i), rand384(), 1, lat_tmp);

    // Reset while the third block is in flight
    lat_blk = (lat_meas - 2) / 3 - 3;
    if (lat_blk < 1) lat_blk = 1;
    off = 2 * (lat_blk + 3) + 2 + lat_blk / 2;
    provided_data = rand384();
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= off + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
      if (done) dones++;
    end
    check("midrst_pre_done", 384'(dones), 384'(0));
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    rst = 1'b0;
    check("midrst_key", 384'(key), 384'(0));
    check("midrst_v", 384'(v), 384'(0));
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst_no_done", 384'(dones), 384'(0));
    mk = '0; mv = '0;
    run_update("post_rst", rand384(), 3, lat_tmp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
